// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 serial transmitter, one frame per accepted start request
module uart_transmit #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic last;
  assign last = cnt == LAST;
  // tx is loaded with the next bit's level on the edge that closes the current bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift <= data_in;
            cnt   <= '0;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            idx   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            shift <= shift >> 1;
            idx   <= idx + 3'd1;
            tx    <= idx == 3'd7 ? 1'b1 : shift[1];
            state <= idx == 3'd7 ? STOP : DATA;
          end
        end
        STOP: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: vector table, corner sequences and random traffic against a frame-timing model
module tb_uart_transmit;
  localparam int C = 4;
  localparam int FL = 10 * C;
  logic clk = 0, rstn = 1, start = 0;
  logic [7:0] data_in = 0;
  logic tx, busy, done;
  int checks = 0, failures = 0, ndone = 0;
  logic chk_en = 0;
  int mt;
  logic [7:0] mb;

  uart_transmit #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rstn(rstn), .start(start), .data_in(data_in),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // model: mt = cycles since the accepting edge, 0 when idle
  always @(posedge clk or negedge rstn)
    if (!rstn) mt <= 0;
    else if (mt == 0) begin
      if (start) begin
        mt <= 1;
        mb <= data_in;
      end
    end else mt <= (mt == FL + 1) ? 0 : mt + 1;

  function automatic logic exp_tx(input int t, input logic [7:0] b);
    int k;
    if (t == 0 || t > FL) return 1'b1;
    k = (t - 1) / C;
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) ndone++;
    if (chk_en) begin
      chk("model_tx", tx, exp_tx(mt, mb));
      chk("model_busy", busy, mt != 0);
      chk("model_done", done, mt == FL + 1);
    end
  end

  typedef struct {
    logic [7:0] b;
    logic [9:0] pat;
    int mode;
    int dones;
  } vec_t;
  vec_t v[6];

  // mode: 0 pulse, 1 held request, 2 data change, 3 pulses while busy, 4 reset at data bit 3
  task automatic frame(input vec_t x);
    int done_at;
    done_at = -1;
    @(negedge clk);
    start = 1;
    data_in = x.b;
    @(posedge clk);
    for (int j = 1; j <= FL + 2; j++) begin
      @(negedge clk);
      if (x.mode != 1) start = x.mode == 3 && (j == 2 || j == 3 * C || j == 9 * C + 2);
      if (x.mode == 2 && j == C + 2) data_in = 8'hFF;
      if (j <= FL && (j - 1) % C == 1) chk($sformatf("tx_bit%0d", (j - 1) / C), tx, x.pat[(j-1)/C]);
      if (done === 1'b1) done_at = j;
      if (x.mode == 4 && j == 4 * C + 2) begin
        #2 rstn = 0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
        return;
      end
      if (x.mode == 1 && j == FL + 2) chk("held_idle_tx", tx, 1);
    end
    chk("done_at", done_at, FL + 1);
    if (x.mode == 1) begin
      @(negedge clk);
      chk("held_restart_tx", tx, 0);
      start = 0;
      repeat (FL + 3) @(negedge clk);
    end
  endtask

  initial begin
    int n0;
    v[0] = '{8'hA5, 10'b1101001010, 0, 1};
    v[1] = '{8'h3C, 10'b1001111000, 1, 2};
    v[2] = '{8'h00, 10'b1000000000, 2, 1};
    v[3] = '{8'hFF, 10'b1111111110, 3, 1};
    v[4] = '{8'hA5, 10'b1101001010, 4, 0};
    v[5] = '{8'h81, 10'b1100000010, 0, 1};
    #3 rstn = 0;
    #1;
    chk("init_tx", tx, 1);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    @(negedge clk);
    rstn = 1;
    chk_en = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n0 = ndone;
      frame(v[i]);
      repeat (3) @(negedge clk);
      chk($sformatf("ndone_vec%0d", i), ndone - n0, v[i].dones);
    end
    repeat (800) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      data_in = 8'($urandom);
    end
    start = 0;
    repeat (FL + 4) @(negedge clk);
    chk("final_idle_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
